ball_fsm: RTL

BALL_FSM -- requirements
Module: ball_fsm

---
 rtl/pong_pkg.sv | 31 +++
 rtl/frame_counter.sv | 21 ++
 rtl/ball_fsm.sv | 118 +++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: screen geometry, bounce event codes, ball FSM state
// encoding and the saturating position step used by the ball.
package pong_pkg;
  localparam int SCREEN_X = 640;
  localparam int SCREEN_Y = 480;
  localparam int POS_W    = 10;
  localparam int CNT_W    = 8;

  localparam logic [1:0] BOUNCE_NONE   = 2'd0;
  localparam logic [1:0] BOUNCE_PADDLE = 2'd1;
  localparam logic [1:0] BOUNCE_WALL   = 2'd2;
  localparam logic [1:0] BOUNCE_SCORE  = 2'd3;

  typedef enum logic [1:0] {
    ST_SERVE    = 2'd0,
    ST_MOVE     = 2'd1,
    ST_COOLDOWN = 2'd2
  } ball_state_e;

  // One axis step in 11-bit arithmetic, clamped to [0, lim] so the ball never wraps.
  function automatic logic [POS_W-1:0] step_sat(input logic [POS_W-1:0] pos,
                                                input logic             dir,
                                                input logic [POS_W:0]   spd,
                                                input logic [POS_W:0]   lim);
    logic [POS_W:0] p, r;
    p = {1'b0, pos};
    if (dir) r = ((p + spd) > lim) ? lim : (p + spd);
    else     r = (p < spd) ? '0 : (p - spd);
    return r[POS_W-1:0];
  endfunction
endpackage

// File: rtl/frame_counter.sv
// Clearable frame_tick counter with terminal-count flag; times both serve and cooldown.
module frame_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == term_i);
endmodule

// File: rtl/ball_fsm.sv
// Pong ball: serve / move / cooldown state machine with saturating per-frame movement
// and one-clock reaction to paddle, wall and score events.
module ball_fsm #(
  parameter int SCREEN_X        = pong_pkg::SCREEN_X,
  parameter int SCREEN_Y        = pong_pkg::SCREEN_Y,
  parameter int BALL_SIZE       = 8,
  parameter int SPEED_X         = 2,
  parameter int SPEED_Y         = 2,
  parameter int SERVE_FRAMES    = 60,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] bounce,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [7:0] ball_size_x,
  output logic [7:0] ball_size_y,
  output logic       ball_moving
);
  import pong_pkg::*;

  localparam logic [POS_W:0]   MAX_X    = (POS_W+1)'(SCREEN_X - BALL_SIZE);
  localparam logic [POS_W:0]   MAX_Y    = (POS_W+1)'(SCREEN_Y - BALL_SIZE);
  localparam logic [POS_W:0]   SPD_X    = (POS_W+1)'(SPEED_X);
  localparam logic [POS_W:0]   SPD_Y    = (POS_W+1)'(SPEED_Y);
  localparam logic [POS_W-1:0] CENTRE_X = POS_W'((SCREEN_X - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] CENTRE_Y = POS_W'((SCREEN_Y - BALL_SIZE) / 2);

  ball_state_e      state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             serve_dir_q, serve_dir_d;
  logic             moving_q;
  logic             cnt_clr, cnt_tc;
  logic [CNT_W-1:0] cnt_term;

  // Counter only runs in SERVE/COOLDOWN and restarts on every state change.
  assign cnt_clr = (state_d != state_q) || (state_q == ST_MOVE);

  frame_counter #(.W(CNT_W)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (frame_tick),
    .term_i (cnt_term),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    serve_dir_d = serve_dir_q;
    cnt_term    = CNT_W'(SERVE_FRAMES - 1);
    if (state_q == ST_COOLDOWN) cnt_term = CNT_W'(COOLDOWN_FRAMES - 1);

    case (state_q)
      ST_SERVE: begin
        if (frame_tick && cnt_tc) state_d = ST_MOVE;
      end
      ST_MOVE, ST_COOLDOWN: begin
        if (bounce == BOUNCE_SCORE) begin
          state_d     = ST_SERVE;
          x_d         = CENTRE_X;
          y_d         = CENTRE_Y;
          dir_x_d     = serve_dir_q;
          serve_dir_d = ~serve_dir_q;
        end else begin
          if (state_q == ST_MOVE && bounce == BOUNCE_PADDLE) begin
            dir_x_d = ~dir_x_q;
            state_d = ST_COOLDOWN;
          end
          if (state_q == ST_MOVE && bounce == BOUNCE_WALL) begin
            dir_y_d = ~dir_y_q;
            state_d = ST_COOLDOWN;
          end
          // Step with the post-bounce direction so a coincident tick moves away.
          if (frame_tick) begin
            x_d = step_sat(x_q, dir_x_d, SPD_X, MAX_X);
            y_d = step_sat(y_q, dir_y_d, SPD_Y, MAX_Y);
            if (state_q == ST_COOLDOWN && cnt_tc) state_d = ST_MOVE;
          end
        end
      end
      default: state_d = ST_SERVE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SERVE;
      x_q         <= CENTRE_X;
      y_q         <= CENTRE_Y;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      serve_dir_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      serve_dir_q <= serve_dir_d;
      moving_q    <= (state_d != ST_SERVE);
    end
  end

  assign ball_pos_x  = x_q;
  assign ball_pos_y  = y_q;
  assign ball_moving = moving_q;
  assign ball_size_x = 8'(BALL_SIZE);
  assign ball_size_y = 8'(BALL_SIZE);
endmodule
